// File: rtl/hazard_sched_if.sv
// Hazard scheduler bundle: ID/EX/MEM hazard inputs and pipeline controls.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_sched_if #(
  parameter int CNT_W = 16
);
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_hold;
  logic       mem_abort;
  logic       mem_err;
  logic [1:0] state;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2,
    output ex_memread, ex_rd, ex_redirect,
    output mem_req, mem_ready,
    input  pc_write, ifid_write,
    input  ifid_flush, idex_flush,
    input  pipe_hold, mem_abort,
    input  mem_err, state,
    input  stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2,
    input  ex_memread, ex_rd, ex_redirect,
    input  mem_req, mem_ready,
    output pc_write, ifid_write,
    output ifid_flush, idex_flush,
    output pipe_hold, mem_abort,
    output mem_err, state,
    output stall_cnt, flush_cnt, memwait_cnt
  );
`else
  localparam int unused_cnt_w = CNT_W;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2,
    output ex_memread, ex_rd, ex_redirect,
    output mem_req, mem_ready,
    input  pc_write, ifid_write,
    input  ifid_flush, idex_flush,
    input  pipe_hold, mem_abort,
    input  mem_err, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2,
    input  ex_memread, ex_rd, ex_redirect,
    input  mem_req, mem_ready,
    output pc_write, ifid_write,
    output ifid_flush, idex_flush,
    output pipe_hold, mem_abort,
    output mem_err, state
  );
`endif
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler: load-use stall, redirect flush, memory wait/timeout.
// Define HAZARD_PERF_EN to add saturating stall/flush/memwait counters.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           reset,
  hazard_sched_if.slave hif
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ABORT   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  state_t     w_cur;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic w_load_use;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_pipe_hold;
  logic w_mem_abort;
  logic w_lu_apply;
  logic w_wait_miss;
  logic w_timeout;

  assign w_rs1_hit = (hif.ex_rd == hif.id_rs1);
  assign w_rs2_hit = hif.id_uses_rs2 &
                     (hif.ex_rd == hif.id_rs2);
  assign w_load_use = hif.ex_memread &
                      (hif.ex_rd != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);

  // Outputs decode as RUN while reset is held.
  assign w_cur = reset ? RUN : r_state;

  assign w_wait_miss = (r_state == MEMWAIT) &
                       !hif.mem_ready;
  assign w_timeout   = w_wait_miss &
                       (r_wait_cnt >= TMO);

  // State register; reset aborts any wait in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; 2'b11 falls back to RUN.
  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN: begin
        if (hif.mem_req && !hif.mem_ready) begin
          w_next = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (hif.mem_ready) begin
          w_next = RUN;
        end else if (r_wait_cnt >= TMO) begin
          w_next = ABORT;
        end else begin
          w_next = MEMWAIT;
        end
      end
      ABORT:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // Pipeline controls: memory hold beats redirect beats load-use.
  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_pipe_hold  = 1'b0;
    w_mem_abort  = 1'b0;
    w_lu_apply   = 1'b0;
    case (w_cur)
      MEMWAIT: w_pipe_hold = !hif.mem_ready;
      ABORT:   w_mem_abort = 1'b1;
      default: begin
        w_pipe_hold = hif.mem_req &
                      !hif.mem_ready;
      end
    endcase
    if (w_pipe_hold) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
    end else if (hif.ex_redirect) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
      w_lu_apply   = 1'b1;
    end
  end

  // Wait counter starts at 1 on the missing cycle, clears otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == RUN) &&
                 hif.mem_req && !hif.mem_ready) begin
      r_wait_cnt <= 8'd1;
    end else if (w_wait_miss && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_err <= 1'b0;
    end else if (w_timeout) begin
      r_mem_err <= 1'b1;
    end
  end

  assign hif.pc_write   = w_pc_write;
  assign hif.ifid_write = w_ifid_write;
  assign hif.ifid_flush = w_ifid_flush;
  assign hif.idex_flush = w_idex_flush;
  assign hif.pipe_hold  = w_pipe_hold;
  assign hif.mem_abort  = w_mem_abort;
  assign hif.mem_err    = r_mem_err;
  assign hif.state      = r_state;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_memwait_cnt;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_memwait_cnt <= '0;
    end else begin
      if (w_lu_apply && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + ONE;
      end
      if (w_ifid_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + ONE;
      end
      if (w_pipe_hold && (r_memwait_cnt != '1)) begin
        r_memwait_cnt <= r_memwait_cnt + ONE;
      end
    end
  end

  assign hif.stall_cnt   = r_stall_cnt;
  assign hif.flush_cnt   = r_flush_cnt;
  assign hif.memwait_cnt = r_memwait_cnt;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
